// File: rtl/counter_seq_ctrl_if.sv
// Command channel for counter_seq_ctrl: valid/ready handshake carrying
// a terminal value (cmd_limit) and an extra-period count (cmd_reps).
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_limit;
  logic [REP_W-1:0] cmd_reps;

  modport master (
    output cmd_valid,
    output cmd_limit,
    output cmd_reps,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_limit,
    input  cmd_reps,
    output cmd_ready
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencer for a free-running up-counter: takes a (limit, reps) command,
// drives cnt_clr/cnt_en, pulses tick per terminal hit and done at the end.
// Ports: clk, rst_n (sync, active-low), cmd (slave: valid/ready/limit/reps),
//   abort, cnt_val in; cnt_en, cnt_clr, tick, done, busy, reps_left out.
// Optional: COUNTER_SEQ_CTRL_PAUSE_EN adds input pause (holds cnt_en in RUN).
module counter_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  counter_seq_ctrl_if.slave cmd,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_val,
`ifdef COUNTER_SEQ_CTRL_PAUSE_EN
  input  logic             pause,
`endif
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [REP_W-1:0] reps_left
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic             hit;
  logic             hold;

`ifdef COUNTER_SEQ_CTRL_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // >= so a counter already past the limit still terminates the period
  assign hit = (cnt_val >= limit_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      limit_q <= '0;
      reps_q  <= '0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      reps_q  <= reps_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    limit_d       = limit_q;
    reps_d        = reps_q;
    cmd.cmd_ready = 1'b0;
    cnt_en        = 1'b0;
    cnt_clr       = 1'b0;
    tick          = 1'b0;
    done          = 1'b0;

    if (abort && state_q != IDLE) begin
      cnt_clr = 1'b1;
      state_d = IDLE;
      reps_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cmd.cmd_ready = 1'b1;
          if (cmd.cmd_valid) begin
            limit_d = cmd.cmd_limit;
            reps_d  = cmd.cmd_reps;
            state_d = CLEAR;
          end
        end
        CLEAR: begin
          cnt_clr = 1'b1;
          state_d = RUN;
        end
        RUN: begin
          // enable drops on the hit cycle so the counter never wraps
          cnt_en = !hit && !hold;
          tick   = hit;
          if (hit) begin
            if (reps_q == '0) begin
              state_d = DONE;
            end else begin
              reps_d  = reps_q - REP_W'(1);
              state_d = CLEAR;
            end
          end
        end
        DONE: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // reset holds the counter at zero and masks every other output
    if (!rst_n) begin
      cmd.cmd_ready = 1'b0;
      cnt_en        = 1'b0;
      cnt_clr       = 1'b1;
      tick          = 1'b0;
      done          = 1'b0;
    end
  end

  assign busy      = rst_n && (state_q != IDLE);
  assign reps_left = rst_n ? reps_q : '0;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl with a behavioural up-counter.
// Stimulus queues expected tick/done events; a monitor pops and compares.
module tb_counter_seq_ctrl;
  localparam int W  = 4;
  localparam int RW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          abort = 1'b0;
`ifdef COUNTER_SEQ_CTRL_PAUSE_EN
  logic          pause = 1'b0;
`endif
  logic [W-1:0]  cnt   = '0;
  logic          cnt_en, cnt_clr, tick, done, busy;
  logic [RW-1:0] reps_left;

  counter_seq_ctrl_if #(.WIDTH(W), .REP_W(RW)) cif ();

  counter_seq_ctrl #(.WIDTH(W), .REP_W(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cif),
    .abort     (abort),
    .cnt_val   (cnt),
`ifdef COUNTER_SEQ_CTRL_PAUSE_EN
    .pause     (pause),
`endif
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .tick      (tick),
    .done      (done),
    .busy      (busy),
    .reps_left (reps_left)
  );

  always #5 clk = ~clk;

  // cyc = number of the last rising edge; values seen mid-cycle
  // are the ones sampled at edge cyc+1
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cnt_clr)     cnt <= '0;
    else if (cnt_en) cnt <= cnt + 1'b1;
  end

  typedef struct {
    int            t;
    logic [W-1:0]  v;
    logic [RW-1:0] r;
  } ev_t;

  ev_t tq[$];
  ev_t dq[$];
  ev_t e;
  int  checks  = 0;
  int  errors  = 0;
  int  cur_lim = 15;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               name, act, exp, cyc + 1);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (edge %0d)", name, cyc + 1);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (tick) begin
        if (tq.size() == 0) flag("unexpected tick");
        else begin
          e = tq.pop_front();
          chk("tick edge", cyc + 1, e.t);
          chk("tick cnt_val", cnt, e.v);
          chk("tick reps_left", reps_left, e.r);
        end
      end else if (tq.size() > 0 && tq[0].t < cyc + 1) begin
        flag("missed tick");
        void'(tq.pop_front());
      end
      if (done) begin
        if (dq.size() == 0) flag("unexpected done");
        else begin
          e = dq.pop_front();
          chk("done edge", cyc + 1, e.t);
          chk("done cnt_val", cnt, e.v);
          chk("done reps_left", reps_left, e.r);
        end
      end else if (dq.size() > 0 && dq[0].t < cyc + 1) begin
        flag("missed done");
        void'(dq.pop_front());
      end
      if (busy && !cnt_clr && cnt > W'(cur_lim))
        chk("cnt bound", cnt, cur_lim);
    end
  end

  // called mid-cycle with the DUT idle; command lands on edge n
  task automatic issue(input int l, input int r, input int st,
                       input bit exp_en, output int n);
    cif.cmd_valid = 1'b1;
    cif.cmd_limit = W'(l);
    cif.cmd_reps  = RW'(r);
    #1;
    chk("cmd_ready idle", cif.cmd_ready, 1);
    n       = cyc + 1;
    cur_lim = l;
    if (exp_en) begin
      for (int i = 0; i <= r; i++)
        tq.push_back('{t: n + (i + 1) * (l + 2) + st,
                       v: W'(l), r: RW'(r - i)});
      dq.push_back('{t: n + (r + 1) * (l + 2) + st + 1,
                     v: W'(l), r: '0});
    end
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    #1;
    chk("clear after accept", cnt_clr, 1);
    chk("busy after accept", busy, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((tq.size() != 0 || dq.size() != 0) && k < budget) begin
      @(negedge clk);
      #3;
      k++;
    end
    if (tq.size() != 0 || dq.size() != 0) begin
      flag("timeout waiting for events");
      tq.delete();
      dq.delete();
    end
    @(negedge clk);
    #1;
    chk("cmd_ready after done", cif.cmd_ready, 1);
    chk("busy after done", busy, 0);
  endtask

  int n;

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_limit = '0;
    cif.cmd_reps  = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst cnt_clr", cnt_clr, 1);
    chk("rst busy", busy, 0);
    chk("rst cmd_ready", cif.cmd_ready, 0);
    chk("rst cnt_en", cnt_en, 0);
    chk("rst tick", tick, 0);
    chk("rst done", done, 0);
    rst_n = 1'b1;
    #1;
    chk("post-rst cmd_ready", cif.cmd_ready, 1);
    chk("post-rst reps_left", reps_left, 0);
    chk("post-rst cnt_clr", cnt_clr, 0);

    // single period, plus a command offered while busy (must be dropped)
    issue(5, 0, 0, 1'b1, n);
    cif.cmd_valid = 1'b1;
    cif.cmd_limit = W'(1);
    #1;
    chk("cmd_ready busy", cif.cmd_ready, 0);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    wait_idle(40);

    issue(3, 2, 0, 1'b1, n);
    wait_idle(40);

    issue(15, 0, 0, 1'b1, n);
    wait_idle(40);

    issue(0, 1, 0, 1'b1, n);
    wait_idle(40);

    // abort mid-run, then a new command on the following edge
    issue(10, 3, 0, 1'b0, n);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort cnt_clr", cnt_clr, 1);
    chk("abort cnt_en", cnt_en, 0);
    chk("abort tick", tick, 0);
    chk("abort done", done, 0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort reps_left", reps_left, 0);
    issue(2, 0, 0, 1'b1, n);
    wait_idle(40);

    // abort while idle is harmless and a same-cycle command is taken
    abort = 1'b1;
    issue(1, 0, 0, 1'b1, n);
    abort = 1'b0;
    wait_idle(40);

`ifdef COUNTER_SEQ_CTRL_PAUSE_EN
    issue(4, 0, 3, 1'b1, n);
    repeat (2) @(negedge clk);
    pause = 1'b1;
    repeat (3) @(negedge clk);
    pause = 1'b0;
    wait_idle(40);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
